// File: rtl/vga_pkg.sv
// Shared 640x480 VGA timing constants and receiver state encoding.
// Used by both the timing generator and the sync receiver.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_START  = 144;
  localparam int V_ACTIVE = 480;
  localparam int V_START  = 35;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } rx_state_t;

endpackage

// File: rtl/vga_sync_receiver_if.sv
// VGA input pins and recovered pixel stream of the sync receiver.
// VGA_FRAME_CHECKSUM_EN adds the per-frame colour checksum.
interface vga_sync_receiver_if #(
  parameter int CW = 10
);

  logic          hsync;
  logic          vsync;
  logic [3:0]    red;
  logic [3:0]    green;
  logic [3:0]    blue;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          pix_valid;
  logic [3:0]    r_out;
  logic [3:0]    g_out;
  logic [3:0]    b_out;
  logic          frame_start;
  logic          locked;
  logic [CW-1:0] h_total;
  logic [CW-1:0] v_total;
`ifdef VGA_FRAME_CHECKSUM_EN
  logic [15:0]   frame_sum;
`endif

  modport master (
    output hsync, vsync, red, green, blue,
    input  x, y, pix_valid,
    input  r_out, g_out, b_out,
    input  frame_start, locked,
    input  h_total, v_total
`ifdef VGA_FRAME_CHECKSUM_EN
    , input frame_sum
`endif
  );

  modport slave (
    input  hsync, vsync, red, green, blue,
    output x, y, pix_valid,
    output r_out, g_out, b_out,
    output frame_start, locked,
    output h_total, v_total
`ifdef VGA_FRAME_CHECKSUM_EN
    , output frame_sum
`endif
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus previous-value register.
// fall pulses while the newest synced sample is the first low one.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic din,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else if (en) begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign fall = prev & ~s2;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: coordinate recovery, line/frame measurement, lock.
// VGA_FRAME_CHECKSUM_EN adds frame_sum over all valid pixels.
module vga_sync_receiver #(
  parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int H_START     = vga_pkg::H_START,
  parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int V_START     = vga_pkg::V_START,
  parameter int LOCK_FRAMES = 2,
  parameter int CW          = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  vga_sync_receiver_if.slave bus
);

  import vga_pkg::*;

  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] H0 = CW'(H_START);
  localparam logic [CW-1:0] H1 = CW'(H_START + H_ACTIVE);
  localparam logic [CW-1:0] V0 = CW'(V_START);
  localparam logic [CW-1:0] V1 = CW'(V_START + V_ACTIVE);
  localparam logic [MW-1:0] MLAST = MW'(LOCK_FRAMES - 1);

  function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  logic          hfall, vfall;
  logic [11:0]   rgb1, rgb2;
  logic [CW-1:0] hcnt, vcnt, hcnt_n, vcnt_n, hlen, vlen;
  logic          hmis, hbad, match, sat;
  logic          go_lock, drop, lock_n, win, valid_n;
  logic [MW-1:0] mcnt;
  rx_state_t     state;

  logic [CW-1:0] x, y, h_total, v_total;
  logic [3:0]    r_out, g_out, b_out;
  logic          pix_valid, frame_start, locked;

  sync_edge_detect u_hs (
    .clk  (clk),
    .reset(reset),
    .en   (pix_en),
    .din  (bus.hsync),
    .fall (hfall)
  );

  sync_edge_detect u_vs (
    .clk  (clk),
    .reset(reset),
    .en   (pix_en),
    .din  (bus.vsync),
    .fall (vfall)
  );

  always_comb begin
    hlen   = inc(hcnt);
    vlen   = inc(vcnt);
    hcnt_n = hfall ? '0 : hlen;
    vcnt_n = vcnt;
    if (vfall)      vcnt_n = '0;
    else if (hfall) vcnt_n = vlen;
    // the line closing on this tick still belongs to the ending frame
    hbad    = hmis || (hfall && (hlen != h_total));
    match   = !hbad && (vlen == v_total);
    sat     = (hcnt_n == CMAX) || (vcnt_n == CMAX);
    go_lock = (state == MEASURE) && vfall && match && (mcnt == MLAST);
    drop    = (state == LOCKED) && ((vfall && !match) || sat);
    lock_n  = go_lock || ((state == LOCKED) && !drop);
    win     = (hcnt_n >= H0) && (hcnt_n < H1) &&
              (vcnt_n >= V0) && (vcnt_n < V1);
    valid_n = win && lock_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      mcnt        <= '0;
      rgb1        <= '0;
      rgb2        <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      hmis        <= 1'b0;
      h_total     <= '0;
      v_total     <= '0;
      x           <= '0;
      y           <= '0;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
    end else begin
      frame_start <= pix_en && vfall;
      if (pix_en) begin
        rgb1 <= {bus.red, bus.green, bus.blue};
        rgb2 <= rgb1;
        hcnt <= hcnt_n;
        vcnt <= vcnt_n;
        hmis <= vfall ? 1'b0 : hbad;
        if (hfall) h_total <= hlen;
        if (vfall) v_total <= vlen;
        x         <= win ? hcnt_n - H0 : '0;
        y         <= win ? vcnt_n - V0 : '0;
        pix_valid <= valid_n;
        r_out     <= valid_n ? rgb2[11:8] : '0;
        g_out     <= valid_n ? rgb2[7:4]  : '0;
        b_out     <= valid_n ? rgb2[3:0]  : '0;
        locked    <= lock_n;
        unique case (state)
          SEARCH: begin
            if (vfall) begin
              state <= MEASURE;
              mcnt  <= '0;
            end
          end
          MEASURE: begin
            if (go_lock) begin
              state <= LOCKED;
              mcnt  <= '0;
            end else if (vfall) begin
              mcnt <= match ? mcnt + MW'(1) : '0;
            end
          end
          LOCKED: begin
            if (drop) state <= SEARCH;
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign bus.x           = x;
  assign bus.y           = y;
  assign bus.pix_valid   = pix_valid;
  assign bus.r_out       = r_out;
  assign bus.g_out       = g_out;
  assign bus.b_out       = b_out;
  assign bus.frame_start = frame_start;
  assign bus.locked      = locked;
  assign bus.h_total     = h_total;
  assign bus.v_total     = v_total;

`ifdef VGA_FRAME_CHECKSUM_EN
  logic [15:0] acc, fsum, add;

  assign add = valid_n ? 16'(rgb2) : 16'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      fsum <= '0;
    end else if (pix_en) begin
      if (vfall) begin
        fsum <= acc;
        acc  <= add;
      end else begin
        acc <= acc + add;
      end
    end
  end

  assign bus.frame_sum = fsum;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a reduced 40x20 raster.
// Visible 24x12 at (10,4); hsync 4 ticks, vsync 2 lines.
module tb_vga_sync_receiver;

  localparam int HT  = 40;
  localparam int VT  = 20;
  localparam int HSW = 4;
  localparam int VSW = 2;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic pix_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int hg   = 0;
  int vg   = 0;
  int hlen = HT;
  bit hold_hi = 1'b0;
  bit cs_mode = 1'b0;

  vga_sync_receiver_if #(.CW(10)) vif ();

  vga_sync_receiver #(
    .H_ACTIVE   (24),
    .H_START    (10),
    .V_ACTIVE   (12),
    .V_START    (4),
    .LOCK_FRAMES(2),
    .CW         (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pix_en(pix_en),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pat(input int h, input int v);
    logic [11:0] c;
    c = 12'h000;
    if (cs_mode)               c = 12'hFFF;
    else if (h == 10 && v == 4)  c = 12'hF0A;
    else if (h == 11 && v == 4)  c = 12'h123;
    else if (h == 9  && v == 4)  c = 12'hABC;
    else if (h == 10 && v == 3)  c = 12'hDEF;
    else if (h == 33 && v == 15) c = 12'h456;
    else if (h == 34 && v == 15) c = 12'h789;
    return c;
  endfunction

  task automatic chk(input string t, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", t, obs, exp);
    end
  endtask

  // one pixel-enable tick; returns at a negedge with pix_en low
  task automatic px();
    @(negedge clk);
    vif.hsync = hold_hi ? 1'b1 : (hg >= HSW);
    vif.vsync = hold_hi ? 1'b1 : (vg >= VSW);
    {vif.red, vif.green, vif.blue} = pat(hg, vg);
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    if (!hold_hi) begin
      hg++;
      if (hg >= hlen) begin
        hg   = 0;
        hlen = HT;
        vg   = (vg == VT - 1) ? 0 : vg + 1;
      end
    end
  endtask

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while (!(hg == h && vg == v) && n < 2 * HT * VT) begin
      px();
      n++;
    end
    if (!(hg == h && vg == v)) begin
      n_fail++;
      $error("FAIL run_to: at %0d,%0d wanted %0d,%0d", hg, vg, h, v);
    end
  endtask

  // drive through the next frame start and let the edge reach the outputs
  task automatic next_edge();
    px();
    run_to(0, 0);
    px();
    px();
    px();
  endtask

  task automatic chk_zero(input string t);
    chk({t, ".x"},  32'(vif.x), 32'd0);
    chk({t, ".y"},  32'(vif.y), 32'd0);
    chk({t, ".pv"}, 32'(vif.pix_valid), 32'd0);
    chk({t, ".rgb"}, 32'({vif.r_out, vif.g_out, vif.b_out}), 32'd0);
    chk({t, ".fs"}, 32'(vif.frame_start), 32'd0);
    chk({t, ".lk"}, 32'(vif.locked), 32'd0);
    chk({t, ".ht"}, 32'(vif.h_total), 32'd0);
    chk({t, ".vt"}, 32'(vif.v_total), 32'd0);
`ifdef VGA_FRAME_CHECKSUM_EN
    chk({t, ".sum"}, 32'(vif.frame_sum), 32'd0);
`endif
  endtask

  task automatic chk_pix(input string t, input int ex, input int ey,
                         input logic pv, input logic [11:0] c);
    chk({t, ".x"},  32'(vif.x), 32'(ex));
    chk({t, ".y"},  32'(vif.y), 32'(ey));
    chk({t, ".pv"}, 32'(vif.pix_valid), 32'(pv));
    chk({t, ".rgb"}, 32'({vif.r_out, vif.g_out, vif.b_out}), 32'(c));
  endtask

  initial begin
    vif.hsync = 1'b1;
    vif.vsync = 1'b1;
    {vif.red, vif.green, vif.blue} = 12'h000;
    #1 reset = 1'b1;
    #1 chk_zero("rst");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    next_edge();
    next_edge();
    chk("lock_e2", 32'(vif.locked), 32'd0);
    next_edge();
    chk("lock_e3", 32'(vif.locked), 32'd1);
    chk("h_total", 32'(vif.h_total), 32'd40);
    chk("v_total", 32'(vif.v_total), 32'd20);
    chk("fs_hi", 32'(vif.frame_start), 32'd1);
    @(negedge clk);
    chk("fs_lo", 32'(vif.frame_start), 32'd0);

    run_to(10, 3);
    px(); px(); px();
    chk_pix("above", 0, 0, 1'b0, 12'h000);
    run_to(9, 4);
    px(); px(); px();
    chk_pix("left", 0, 0, 1'b0, 12'h000);
    px();
    chk_pix("first", 0, 0, 1'b1, 12'hF0A);
    px();
    chk_pix("second", 1, 0, 1'b1, 12'h123);
    run_to(33, 15);
    px(); px(); px();
    chk_pix("last", 23, 11, 1'b1, 12'h456);
    px();
    chk_pix("right", 0, 0, 1'b0, 12'h000);

    run_to(0, 8);
    hlen = HT - 1;
    run_to(0, 12);
    chk("short_hold", 32'(vif.locked), 32'd1);
    next_edge();
    chk("short_drop", 32'(vif.locked), 32'd0);
    next_edge();
    next_edge();
    chk("short_e7", 32'(vif.locked), 32'd0);
    next_edge();
    chk("short_relock", 32'(vif.locked), 32'd1);

    run_to(0, 5);
    hold_hi = 1'b1;
    repeat (2000) px();
    chk("sat_lk", 32'(vif.locked), 32'd0);
    chk("sat_pv", 32'(vif.pix_valid), 32'd0);
    hold_hi = 1'b0;
    hg = 0;
    vg = 0;
    hlen = HT;
    px(); px(); px();
    chk("sat_ht", 32'(vif.h_total), 32'd1023);
    chk("sat_fs", 32'(vif.frame_start), 32'd1);
    next_edge();
    next_edge();
    chk("sat_e3", 32'(vif.locked), 32'd0);
    next_edge();
    chk("sat_relock", 32'(vif.locked), 32'd1);

    run_to(20, 8);
    #2 reset = 1'b1;
    #1 chk_zero("rst_mid");
    px();
    px();
    reset = 1'b0;
    next_edge();
    next_edge();
    next_edge();
    chk("rst_e3", 32'(vif.locked), 32'd0);
    next_edge();
    chk("rst_relock", 32'(vif.locked), 32'd1);

`ifdef VGA_FRAME_CHECKSUM_EN
    cs_mode = 1'b1;
    next_edge();
    chk("frame_sum", 32'(vif.frame_sum), 32'd65248);
    cs_mode = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
